ahb_burst_master_addr: RTL and testbench

Address-phase generator for the initiator side of the AHB-lite bus on `hclk`. It drives `haddr`, `htrans`, `hburst` and `hsize` for single, incrementing and wrapping bursts. A local stall request inserts BUSY cycles, and the next-beat address is held stable from each BUSY cycle into the following SEQ cycle. It sits between the local DMA/request logic and the bus, and supplies the address side that the bus-level assertion checker monitors.

---
 rtl/ahb_pkg.sv | 56 +++++
 rtl/ahb_addr_step.sv | 29 ++
 rtl/ahb_burst_master_addr.sv | 119 +++++++++++
 tb/tb_ahb_burst_master_addr.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-lite definitions for the burst address generator:
// transfer-type encoding, HBURST/HSIZE codes and burst geometry helpers.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Undefined-length INCR is not supported and runs as a single beat.
  function automatic logic [4:0] beats_of(input logic [2:0] hburst);
    logic [4:0] n;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  n = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  n = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: n = 5'd16;
      default:                      n = 5'd1;
    endcase
    return n;
  endfunction

  function automatic logic is_wrap(input logic [2:0] hburst);
    return (hburst == HBURST_WRAP4) || (hburst == HBURST_WRAP8) ||
           (hburst == HBURST_WRAP16);
  endfunction

  // Sizes above a word are not supported; they run as word transfers.
  function automatic logic [2:0] clamp_size(input logic [2:0] hsize);
    return (hsize > HSIZE_WORD) ? HSIZE_WORD : hsize;
  endfunction

  // Low address bits that cycle within the wrap span (beats * bytes - 1);
  // zero for incrementing bursts. Largest span is 16 words = 64 bytes.
  function automatic logic [6:0] wrap_mask(input logic [2:0] hburst,
                                           input logic [2:0] hsize);
    logic [6:0] span;
    span = 7'(beats_of(hburst)) << hsize;
    return is_wrap(hburst) ? (span - 7'd1) : 7'd0;
  endfunction

endpackage

// File: rtl/ahb_addr_step.sv
// Combinational next-beat address for incrementing and wrapping bursts.
module ahb_addr_step
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        hburst,
  input  logic [2:0]        hsize,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] mask;

  // Wrapping bursts keep the bits above the span and let the low bits roll over.
  always_comb begin
    step = ADDR_W'(1) << hsize;
    inc  = addr + step;
    mask = ADDR_W'(wrap_mask(hburst, hsize));
    if (is_wrap(hburst)) begin
      next_addr = (addr & ~mask) | (inc & mask);
    end else begin
      next_addr = inc;
    end
  end

endmodule

// File: rtl/ahb_burst_master_addr.sv
// AHB-lite initiator address phase: FSM, beat counter and registered
// haddr/htrans/hburst/hsize. The FSM state register drives htrans directly.
//
// Handshake: an address phase (NONSEQ or SEQ) is accepted on a rising edge
// where hready=1; with hready=0 nothing moves. start is a level request that
// is honoured only in IDLE and must stay high until active rises; done is a
// single-cycle indication (while hready stays high) that the last beat left.
module ahb_burst_master_addr
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [2:0]        burst_in,
  input  logic [2:0]        size_in,
  input  logic              stall_req,
  input  logic              hready,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hburst,
  output logic [2:0]        hsize,
  output logic              active,
  output logic              done
);

  htrans_t           state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [3:0]        rem_q, rem_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] next_addr;
  logic [2:0]        size_c;

  ahb_addr_step #(.ADDR_W(ADDR_W)) u_step (
    .addr      (haddr_q),
    .hburst    (hburst_q),
    .hsize     (hsize_q),
    .next_addr (next_addr)
  );

  assign size_c = clamp_size(size_in);

  // Next-state and next-output logic; rem_q counts beats after the one on haddr.
  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hburst_d = hburst_q;
    hsize_d  = hsize_q;
    rem_d    = rem_q;
    active_d = active_q;
    done_d   = done_q;
    if (hready) begin
      case (state_q)
        HT_IDLE: begin
          done_d = 1'b0;
          if (start) begin
            state_d  = HT_NONSEQ;
            haddr_d  = start_addr & ~((ADDR_W'(1) << size_c) - ADDR_W'(1));
            hburst_d = burst_in;
            hsize_d  = size_c;
            rem_d    = 4'(beats_of(burst_in) - 5'd1);
            active_d = 1'b1;
          end
        end
        HT_NONSEQ, HT_SEQ: begin
          if (rem_q == 4'd0) begin
            state_d  = HT_IDLE;
            active_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            rem_d   = rem_q - 4'd1;
            haddr_d = next_addr;
            state_d = stall_req ? HT_BUSY : HT_SEQ;
          end
        end
        HT_BUSY: begin
          if (!stall_req) begin
            state_d = HT_SEQ;
          end
        end
        default: state_d = HT_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q  <= HT_IDLE;
      haddr_q  <= '0;
      hburst_q <= '0;
      hsize_q  <= '0;
      rem_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hburst_q <= hburst_d;
      hsize_q  <= hsize_d;
      rem_q    <= rem_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign haddr  = haddr_q;
  assign htrans = state_q;
  assign hburst = hburst_q;
  assign hsize  = hsize_q;
  assign active = active_q;
  assign done   = done_q;

endmodule

// File: tb/tb_ahb_burst_master_addr.sv
// Bench for ahb_burst_master_addr: directed bursts from the test plan plus
// random bursts with random hready/stall, checked by a negedge monitor.
module tb_ahb_burst_master_addr;

  localparam int AW = 32;
  localparam int EW = 41; // {trans[40:39], burst[38:36], size[35:33], last[32], addr[31:0]}

  logic          hclk;
  logic          hrst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [2:0]    burst_in;
  logic [2:0]    size_in;
  logic          stall_req;
  logic          hready;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic [2:0]    hburst;
  logic [2:0]    hsize;
  logic          active;
  logic          done;

  ahb_burst_master_addr #(.ADDR_W(AW)) dut (
    .hclk       (hclk),
    .hrst       (hrst),
    .start      (start),
    .start_addr (start_addr),
    .burst_in   (burst_in),
    .size_in    (size_in),
    .stall_req  (stall_req),
    .hready     (hready),
    .haddr      (haddr),
    .htrans     (htrans),
    .hburst     (hburst),
    .hsize      (hsize),
    .active     (active),
    .done       (done)
  );

  // ---------------- clock / reset ----------------
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: burst length and address of beat i from the burst rules.
  function automatic int beats_f(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [2:0] b,
                                             input logic [2:0] s, input int i);
    int unsigned sz, step, a0, span, base;
    sz   = (s > 3'd2) ? 2 : int'(s);
    step = 1 << sz;
    a0   = a - (a % step);
    if (b == 3'd2 || b == 3'd4 || b == 3'd6) begin
      span = beats_f(b) * step;
      base = a0 - (a0 % span);
      return base + ((a0 - base + i * step) % span);
    end
    return a0 + i * step;
  endfunction

  task automatic push_burst(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s);
    int n;
    logic [2:0] sc;
    n  = beats_f(b);
    sc = (s > 3'd2) ? 3'd2 : s;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == 0) ? 2'b10 : 2'b11, b, sc, (i == n - 1), model_addr(a, b, s, i)});
    end
  endtask

  // ---------------- monitor ----------------
  logic          have_prev = 1'b0;
  logic          p_rst, p_hready, p_stall, p_start, p_last, p_active, p_done;
  logic [1:0]    p_trans;
  logic [AW-1:0] p_addr;
  logic [2:0]    p_burst, p_size;

  always @(negedge hclk) begin
    logic [EW-1:0] e;
    logic cur_last;
    if (have_prev) begin
      if (p_rst) begin
        check("reset_haddr", haddr, 0);
        check("reset_htrans", htrans, 2'b00);
        check("reset_hburst", hburst, 0);
        check("reset_hsize", hsize, 0);
        check("reset_done", done, 0);
      end else if (!p_hready) begin
        check("frozen_haddr", haddr, p_addr);
        check("frozen_htrans", htrans, p_trans);
        check("frozen_hburst", hburst, p_burst);
        check("frozen_hsize", hsize, p_size);
        check("frozen_active", active, p_active);
        check("frozen_done", done, p_done);
      end else begin
        case (p_trans)
          2'b00: begin
            check("idle_next_htrans", htrans, p_start ? 2'b10 : 2'b00);
            check("idle_done_low", done, 0);
          end
          2'b10, 2'b11: begin
            if (p_last) begin
              check("last_beat_to_idle", htrans, 2'b00);
              check("last_beat_done", done, 1);
            end else begin
              check("beat_next_htrans", htrans, p_stall ? 2'b01 : 2'b11);
              check("beat_done_low", done, 0);
            end
          end
          default: begin
            check("busy_next_htrans", htrans, p_stall ? 2'b01 : 2'b11);
            check("busy_haddr_held", haddr, p_addr);
            check("busy_hburst_held", hburst, p_burst);
            check("busy_hsize_held", hsize, p_size);
          end
        endcase
      end
      check("active_vs_htrans", active, (htrans != 2'b00));
    end
    cur_last = 1'b0;
    if (!hrst && hready && (htrans == 2'b10 || htrans == 2'b11)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got addr 0x%0h htrans %0b, expected no beat", haddr, htrans);
      end else begin
        e = exp_q.pop_front();
        check("beat_haddr", haddr, e[31:0]);
        check("beat_htrans", htrans, e[40:39]);
        check("beat_hburst", hburst, e[38:36]);
        check("beat_hsize", hsize, e[35:33]);
        cur_last = e[32];
      end
    end
    p_rst     = hrst;
    p_hready  = hready;
    p_stall   = stall_req;
    p_start   = start;
    p_trans   = htrans;
    p_addr    = haddr;
    p_burst   = hburst;
    p_size    = hsize;
    p_active  = active;
    p_done    = done;
    p_last    = cur_last;
    have_prev = 1'b1;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Bit c of stall_bits/rdy_bits drives the edge that ends cycle c (cycle 0
  // is the one where start is first raised). rnd replaces them with random values.
  task automatic run_burst(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                           input logic [31:0] stall_bits, input logic [31:0] rdy_bits,
                           input bit rnd);
    int cyc;
    bit seen_active;
    cyc = 0;
    seen_active = 1'b0;
    push_burst(a, b, s);
    start_addr = a;
    burst_in   = b;
    size_in    = s;
    start      = 1'b1;
    while (1) begin
      if (rnd) begin
        hready    = ($urandom_range(0, 3) != 0);
        stall_req = ($urandom_range(0, 3) == 0);
      end else begin
        hready    = (cyc < 32) ? rdy_bits[cyc] : 1'b1;
        stall_req = (cyc < 32) ? stall_bits[cyc] : 1'b0;
      end
      tick();
      cyc++;
      if (active) begin
        seen_active = 1'b1;
        start = 1'b0;
      end
      if (seen_active && done) break;
      if (cyc > 300) begin
        n_cmp++;
        n_bad++;
        $display("FAIL burst_timeout: got no done within 300 cycles, expected done for burst at 0x%0h", a);
        start = 1'b0;
        break;
      end
    end
    hready    = 1'b1;
    stall_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    hrst       = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    burst_in   = '0;
    size_in    = '0;
    stall_req  = 1'b0;
    hready     = 1'b1;
    repeat (3) tick();
    hrst = 1'b0;
    tick();

    run_burst(32'h100, 3'd0, 3'd2, 32'h0, 32'hFFFF_FFFF, 1'b0);   // SINGLE word
    run_burst(32'h200, 3'd3, 3'd2, 32'h0, 32'hFFFF_FFFF, 1'b0);   // INCR4 word
    run_burst(32'h38,  3'd2, 3'd2, 32'h0, 32'hFFFF_FFFF, 1'b0);   // WRAP4 word
    run_burst(32'h0E,  3'd4, 3'd1, 32'h0, 32'hFFFF_FFFF, 1'b0);   // WRAP8 half
    run_burst(32'h10,  3'd3, 3'd2, 32'h0000_000C, 32'hFFFF_FFFF, 1'b0); // stall 2 cycles after beat 2
    run_burst(32'h400, 3'd5, 3'd2, 32'h0, ~32'h0000_0038, 1'b0);  // hready low 3 cycles at beat 3
    run_burst(32'h0,   3'd3, 3'd2, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0); // stall on last beat
    run_burst(32'h44,  3'd1, 3'd0, 32'h0, 32'hFFFF_FFFF, 1'b0);   // INCR runs as single
    run_burst(32'h1237, 3'd3, 3'd3, 32'h0, 32'hFFFF_FFFF, 1'b0);  // size clamp + alignment
    run_burst(32'hFFFF_FFF8, 3'd3, 3'd2, 32'h0, 32'hFFFF_FFFF, 1'b0); // address wrap-around
    run_burst(32'h5A, 3'd6, 3'd0, 32'h0000_0A50, 32'hFFFF_FFFF, 1'b0); // WRAP16 byte with stalls

    // Reset in the middle of a WRAP8 burst, then restart right away.
    push_burst(32'h70, 3'd4, 3'd2);
    start_addr = 32'h70;
    burst_in   = 3'd4;
    size_in    = 3'd2;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    hrst = 1'b1;
    tick();
    exp_q.delete();
    hrst = 1'b0;
    run_burst(32'h300, 3'd3, 3'd2, 32'h0, 32'hFFFF_FFFF, 1'b0);

    // Random bursts with random bus back-pressure and local stalls.
    repeat (60) begin
      logic [31:0] a;
      logic [2:0]  b, s;
      a = $urandom();
      b = 3'($urandom_range(0, 7));
      s = 3'($urandom_range(0, 3));
      run_burst(a, b, s, 32'h0, 32'hFFFF_FFFF, 1'b1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    repeat (3) tick();
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
